// File: rtl/uart_rx_packet_parser.sv
// uart_rx_packet_parser: frames SOF/LEN/payload/checksum bytes from a UART receiver and streams the payload out over valid/ready.
// Optional inter-byte timeout is enabled by defining UART_PKT_TIMEOUT_EN.
module uart_rx_packet_parser #(
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       system_clk,
    input  logic       rst,
    input  logic       rx_done,
    input  logic [7:0] rx_byte,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic [7:0] pkt_len,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic [2:0] flag_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        LEN     = 3'b001,
        PAYLOAD = 3'b010,
        CHECK   = 3'b011,
        DRAIN   = 3'b100
    } state_t;

    localparam int         AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_L = 8'(MAX_LEN);

    state_t     state, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] acc, acc_d;
    logic [7:0] count, count_d;
    logic [7:0] rd_idx, rd_idx_d;
    logic       err_d;
    logic [1:0] code_d;
    logic       wr_en;
    logic       handshake;
    logic       timeout;
    logic [7:0] mem [MAX_LEN];

    assign flag_state = state;
    assign pkt_valid  = state == DRAIN;
    assign handshake  = pkt_valid && pkt_ready;
    assign pkt_last   = pkt_valid && (rd_idx == len_q - 8'd1);
    assign pkt_data   = pkt_valid ? mem[rd_idx[AW-1:0]] : 8'h00;

`ifdef UART_PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          active;
    assign active  = state inside {LEN, PAYLOAD, CHECK};
    // A byte arriving in the terminal cycle wins over the timeout.
    assign timeout = active && !rx_done && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge system_clk or posedge rst) begin
        if (rst)
            tcnt <= '0;
        else if (rx_done || !active || timeout)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state;
        len_d    = len_q;
        acc_d    = acc;
        count_d  = count;
        rd_idx_d = rd_idx;
        err_d    = 1'b0;
        code_d   = 2'b00;
        wr_en    = 1'b0;
        case (state)
            IDLE: state_d = (rx_done && rx_byte == SOF_BYTE) ? LEN : IDLE;
            LEN: if (rx_done) begin
                len_d = rx_byte;
                if (rx_byte == 8'd0 || rx_byte > MAX_L) begin
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                    state_d = IDLE;
                end else begin
                    acc_d   = rx_byte;
                    count_d = 8'd0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (rx_done) begin
                wr_en   = 1'b1;
                acc_d   = acc + rx_byte;
                count_d = count + 8'd1;
                state_d = (count_d == len_q) ? CHECK : PAYLOAD;
            end
            CHECK: if (rx_done) begin
                if (rx_byte == acc) begin
                    rd_idx_d = 8'd0;
                    state_d  = DRAIN;
                end else begin
                    err_d   = 1'b1;
                    code_d  = 2'b01;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // Bytes arriving while draining are dropped, never parsed.
                err_d  = rx_done;
                code_d = rx_done ? 2'b11 : 2'b00;
                if (handshake) begin
                    rd_idx_d = rd_idx + 8'd1;
                    state_d  = pkt_last ? IDLE : DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            err_d   = 1'b1;
            code_d  = 2'b00;
            state_d = IDLE;
        end
    end

    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            len_q    <= 8'd0;
            acc      <= 8'd0;
            count    <= 8'd0;
            rd_idx   <= 8'd0;
            pkt_err  <= 1'b0;
            err_code <= 2'b00;
            pkt_len  <= 8'd0;
        end else begin
            state    <= state_d;
            len_q    <= len_d;
            acc      <= acc_d;
            count    <= count_d;
            rd_idx   <= rd_idx_d;
            pkt_err  <= err_d;
            err_code <= code_d;
            if (state == CHECK && state_d == DRAIN)
                pkt_len <= len_q;
        end
    end

    always_ff @(posedge system_clk) begin
        if (wr_en)
            mem[count[AW-1:0]] <= rx_byte;
    end

endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// tb_uart_rx_packet_parser: table-driven packets with a scoreboard of expected beats and error codes.
module tb_uart_rx_packet_parser;

    logic       system_clk = 1'b0;
    logic       rst        = 1'b1;
    logic       rx_done    = 1'b0;
    logic [7:0] rx_byte    = 8'h00;
    logic       pkt_ready  = 1'b1;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_last;
    logic [7:0] pkt_len;
    logic       pkt_err;
    logic [1:0] err_code;
    logic [2:0] flag_state;

    uart_rx_packet_parser #(.SOF_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYCLES(50)) dut (
        .system_clk(system_clk),
        .rst(rst),
        .rx_done(rx_done),
        .rx_byte(rx_byte),
        .pkt_data(pkt_data),
        .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready),
        .pkt_last(pkt_last),
        .pkt_len(pkt_len),
        .pkt_err(pkt_err),
        .err_code(err_code),
        .flag_state(flag_state)
    );

    always #5 system_clk = ~system_clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] len;
    } beat_t;

    typedef struct {
        logic [159:0] bytes;
        int           n;
        int           off;
        int           pay;
        int           code;
    } row_t;

    beat_t      exp_q[$];
    logic [1:0] err_q[$];
    beat_t      e;
    row_t       rows[10];
    row_t       r;
    int         vecs = 0;
    int         errs = 0;
    int         vcyc = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data;
    logic       stall_last;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] nth(input logic [159:0] v, input int n, input int i);
        return v[8*(n-1-i) +: 8];
    endfunction

    always @(negedge system_clk) begin
        if (!rst) begin
            if (stall_prev) begin
                check("hold_valid", pkt_valid, 1);
                check("hold_data", pkt_data, stall_data);
                check("hold_last", pkt_last, stall_last);
            end
            stall_prev = pkt_valid && !pkt_ready;
            stall_data = pkt_data;
            stall_last = pkt_last;
            if (pkt_valid) vcyc++;
            if (pkt_err) begin
                check("err_expected", err_q.size() != 0, 1);
                if (err_q.size() != 0) check("err_code", err_code, err_q.pop_front());
            end
            if (pkt_valid && pkt_ready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("pkt_data", pkt_data, e.data);
                    check("pkt_last", pkt_last, e.last);
                    check("pkt_len", pkt_len, e.len);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge system_clk);
        #1 rx_done = 1'b1;
        rx_byte = b;
        @(posedge system_clk);
        #1 rx_done = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300; i++) begin
            @(posedge system_clk);
            #1;
            if (flag_state == 3'd0 && exp_q.size() == 0 && err_q.size() == 0) break;
        end
        check("settle", i < 300, 1);
    endtask

    task automatic push_row(input row_t x);
        for (int k = 0; k < x.pay; k++)
            exp_q.push_back('{nth(x.bytes, x.n, x.off + k), k == x.pay - 1, 8'(x.pay)});
        if (x.code >= 0) err_q.push_back(2'(x.code));
    endtask

    task automatic run_row(input row_t x);
        vcyc = 0;
        push_row(x);
        for (int i = 0; i < x.n; i++) send(nth(x.bytes, x.n, i));
        wait_idle();
        check("valid_cycles", vcyc, x.pay);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, pkt_valid, 0);
        check({tag, "_data"}, pkt_data, 0);
        check({tag, "_last"}, pkt_last, 0);
        check({tag, "_len"}, pkt_len, 0);
        check({tag, "_err"}, pkt_err, 0);
        check({tag, "_code"}, err_code, 0);
        check({tag, "_state"}, flag_state, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rows[0] = '{160'hA50311223369, 6, 2, 3, -1};
        rows[1] = '{160'hA5031122336A, 6, 2, 0, 1};
        rows[2] = '{160'hA500, 2, 0, 0, 2};
        rows[3] = '{160'hA511, 2, 0, 0, 2};
        rows[4] = '{160'hA5017E7F, 4, 2, 1, -1};
        rows[5] = '{160'h00FF5AA502010205, 8, 5, 2, -1};
        rows[6] = '{160'hA502A5A54C, 5, 2, 2, -1};
        rows[7] = '{160'hA5FF, 2, 0, 0, 2};
        rows[8] = '{160'hA501FF00, 4, 2, 1, -1};
        rows[9] = '{160'hA5100102030405060708090A0B0C0D0E0F1098, 19, 2, 16, -1};

        #2;
        check_zero_outputs("reset");
        repeat (3) @(posedge system_clk);
        #1 rst = 1'b0;

        for (int t = 0; t < 10; t++) run_row(rows[t]);

        // Stall with an overrun byte arriving mid-drain.
        r = '{160'hA502010205, 5, 2, 2, -1};
        push_row(r);
        pkt_ready = 1'b0;
        vcyc = 0;
        for (int i = 0; i < r.n; i++) send(nth(r.bytes, r.n, i));
        check("stall_valid", pkt_valid, 1);
        err_q.push_back(2'b11);
        rx_done = 1'b1;
        rx_byte = 8'h99;
        @(posedge system_clk);
        #1 rx_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge system_clk);
            #1 pkt_ready = ~pkt_ready;
        end
        wait_idle();
        pkt_ready = 1'b1;

        // Last-byte handshake coinciding with an overrun SOF byte.
        r = '{160'hA5014243, 4, 2, 1, -1};
        push_row(r);
        for (int i = 0; i < r.n; i++) send(nth(r.bytes, r.n, i));
        check("last_pending", pkt_last, 1);
        err_q.push_back(2'b11);
        rx_done = 1'b1;
        rx_byte = 8'hA5;
        @(posedge system_clk);
        #1 rx_done = 1'b0;
        check("last_overrun_state", flag_state, 0);
        send(8'h02);
        wait_idle();
        check("sof_not_parsed", flag_state, 0);

        // Reset mid-packet.
        send(8'hA5);
        send(8'h04);
        send(8'hAA);
        send(8'hBB);
        check("mid_state", flag_state, 2);
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        repeat (2) @(posedge system_clk);
        #1 rst = 1'b0;
        run_row('{160'hA5015556, 4, 2, 1, -1});

        // Inter-byte timeout.
        send(8'hA5);
        send(8'h02);
        send(8'h10);
`ifdef UART_PKT_TIMEOUT_EN
        err_q.push_back(2'b00);
`endif
        repeat (60) @(posedge system_clk);
        #1;
`ifdef UART_PKT_TIMEOUT_EN
        check("timeout_state", flag_state, 0);
        check("timeout_seen", err_q.size(), 0);
`else
        check("no_timeout_state", flag_state, 2);
`endif
        check("beats_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
